// File: rtl/proc_pkg.sv
// Shared definitions for the processor control unit: opcodes, time steps, IR field positions.
package proc_pkg;

    localparam int IR_W   = 9;
    localparam int OPC_HI = 8;
    localparam int OPC_LO = 6;
    localparam int X_HI   = 5;
    localparam int X_LO   = 3;
    localparam int Y_HI   = 2;
    localparam int Y_LO   = 0;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } tstep_e;

    // add and sub share the three-step ALU sequence and differ only in IR[6]
    function automatic logic is_alu(input logic [2:0] opc);
        return (opc == OP_ADD) || (opc == OP_SUB);
    endfunction

endpackage

// File: rtl/proc_ctrl_regn.sv
// Generic enabled register with asynchronous active-low clear.
module regn #(
    parameter int N = 9
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] q_o
);

    logic [N-1:0] q_q;

    // Load on enable, clear on reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)    q_q <= '0;
        else if (en_i)  q_q <= d_i;
    end

    assign q_o = q_q;

endmodule

// File: rtl/proc_ctrl.sv
// Control unit of the simple processor: fetches a 9-bit instruction and sequences T0..T3,
// driving the Rin/Rout decoder selects and the datapath strobes.
module proc_ctrl
    import proc_pkg::*;
#(
    parameter int DATA_W = 9
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Run,
    input  logic [DATA_W-1:0] DIN,
    output logic              IRin,
    output logic [2:0]        Xsel,
    output logic              Xen,
    output logic [2:0]        Ysel,
    output logic              Yen,
    output logic              DINout,
    output logic              Ain,
    output logic              Gin,
    output logic              Gout,
    output logic              AddSub,
    output logic              Done
);

    tstep_e            tstep_q, tstep_d;
    logic [IR_W-1:0]   ir_q;
    logic [2:0]        opc, fx, fy;

    // Upper DIN bits carry nothing the controller needs
    if (DATA_W > IR_W) begin : g_din_hi
        logic unused_din_hi;
        assign unused_din_hi = ^DIN[DATA_W-1:IR_W];
    end

    regn #(.N(IR_W)) u_ir (
        .clk_i  (Clock),
        .rst_ni (Resetn),
        .en_i   (IRin),
        .d_i    (DIN[IR_W-1:0]),
        .q_o    (ir_q)
    );

    assign opc = ir_q[OPC_HI:OPC_LO];
    assign fx  = ir_q[X_HI:X_LO];
    assign fy  = ir_q[Y_HI:Y_LO];

    // Step decode: outputs and next step from current step, IR and Run
    always_comb begin
        tstep_d = tstep_q;
        IRin    = 1'b0;
        Xsel    = 3'd0;
        Xen     = 1'b0;
        Ysel    = 3'd0;
        Yen     = 1'b0;
        DINout  = 1'b0;
        Ain     = 1'b0;
        Gin     = 1'b0;
        Gout    = 1'b0;
        AddSub  = 1'b0;
        Done    = 1'b0;
        unique case (tstep_q)
            T0: begin
                // gated so the IR load strobe is silent while reset is asserted
                IRin = Run & Resetn;
                if (Run) tstep_d = T1;
            end
            T1: begin
                if (opc == OP_MV) begin
                    Ysel = fy;  Yen = 1'b1;
                    Xsel = fx;  Xen = 1'b1;
                    Done = 1'b1;
                end else if (opc == OP_MVI) begin
                    DINout = 1'b1;
                    Xsel   = fx;  Xen = 1'b1;
                    Done   = 1'b1;
                end else if (is_alu(opc)) begin
                    // Rx goes to the bus first so it lands in A
                    Ysel = fx;  Yen = 1'b1;
                    Ain  = 1'b1;
                end else begin
                    Done = 1'b1;
                end
                tstep_d = Done ? T0 : T2;
            end
            T2: begin
                if (is_alu(opc)) begin
                    Ysel   = fy;  Yen = 1'b1;
                    Gin    = 1'b1;
                    AddSub = ir_q[OPC_LO];
                    tstep_d = T3;
                end else begin
                    // unreachable for legal sequences; fall back to fetch
                    tstep_d = T0;
                end
            end
            T3: begin
                if (is_alu(opc)) begin
                    Gout = 1'b1;
                    Xsel = fx;  Xen = 1'b1;
                    Done = 1'b1;
                end
                tstep_d = T0;
            end
            default: tstep_d = T0;
        endcase
    end

    // Time-step register
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) tstep_q <= T0;
        else         tstep_q <= tstep_d;
    end

endmodule

// File: tb/tb_proc_ctrl.sv
// Self-checking bench for proc_ctrl: directed instruction sequences plus randomized traffic,
// checked against a per-instruction expected-cycle queue.
module tb_proc_ctrl;

    logic       Clock = 1'b0;
    logic       Resetn;
    logic       Run;
    logic [8:0] DIN;
    logic       IRin, Xen, Yen, DINout, Ain, Gin, Gout, AddSub, Done;
    logic [2:0] Xsel, Ysel;

    int checks = 0;
    int errors = 0;

    logic [14:0] pend[$];
    logic [14:0] outs;

    proc_ctrl #(.DATA_W(9)) dut (
        .Clock(Clock), .Resetn(Resetn), .Run(Run), .DIN(DIN),
        .IRin(IRin), .Xsel(Xsel), .Xen(Xen), .Ysel(Ysel), .Yen(Yen),
        .DINout(DINout), .Ain(Ain), .Gin(Gin), .Gout(Gout),
        .AddSub(AddSub), .Done(Done)
    );

    always #5 Clock = ~Clock;

    assign outs = {IRin, Xsel, Xen, Ysel, Yen, DINout, Ain, Gin, Gout, AddSub, Done};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [14:0] mk(input logic irin, input logic [2:0] xs, input logic xe,
                                       input logic [2:0] ys, input logic ye, input logic dno,
                                       input logic ai, input logic gi, input logic go,
                                       input logic as, input logic dn);
        return {irin, xs, xe, ys, ye, dno, ai, gi, go, as, dn};
    endfunction

    // Expected output words for every cycle after the fetch, straight from the opcode table
    task automatic queue_instr(input logic [8:0] ins);
        logic [2:0] op, x, y;
        op = ins[8:6]; x = ins[5:3]; y = ins[2:0];
        case (op)
            3'b000: pend.push_back(mk(0, x, 1, y, 1, 0, 0, 0, 0, 0, 1));
            3'b001: pend.push_back(mk(0, x, 1, 0, 0, 1, 0, 0, 0, 0, 1));
            3'b010, 3'b011: begin
                pend.push_back(mk(0, 0, 0, x, 1, 0, 1, 0, 0, 0, 0));
                pend.push_back(mk(0, 0, 0, y, 1, 0, 0, 1, 0, op[0], 0));
                pend.push_back(mk(0, x, 1, 0, 0, 0, 0, 0, 1, 0, 1));
            end
            default: pend.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        endcase
    endtask

    function automatic logic [14:0] expected(input logic run);
        if (pend.size() == 0) return mk(run, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        return pend[0];
    endfunction

    // One cycle: drive, check mid-cycle, advance model, move past the edge
    task automatic step(input string tag, input logic run, input logic [8:0] din);
        Run = run; DIN = din;
        #3;
        chk(tag, outs, expected(run));
        chk("bus_excl", (32'(Yen) + 32'(DINout) + 32'(Gout)) <= 1, 1);
        if (pend.size() == 0) begin
            if (run) queue_instr(din);
        end else begin
            void'(pend.pop_front());
        end
        @(posedge Clock); #1;
    endtask

    initial begin
        // reset with Run high and all-ones DIN: everything quiet
        Resetn = 1'b0; Run = 1'b1; DIN = 9'h1FF;
        #2;
        chk("rst_outs", outs, 0);
        @(posedge Clock); #1;
        chk("rst_outs2", outs, 0);
        chk("rst_ir", dut.ir_q, 0);
        Resetn = 1'b1; Run = 1'b0;
        for (int i = 0; i < 3; i++) step("idle", 1'b0, 9'h1FF);

        // mvi R2,#5
        step("mvi_t0", 1'b1, 9'b001_010_000);
        step("mvi_t1", 1'b0, 9'd5);
        step("mvi_back", 1'b0, 9'd0);

        // mv R1,R3
        step("mv_t0", 1'b1, 9'b000_001_011);
        step("mv_t1", 1'b0, 9'd0);

        // add R0,R1 then sub R0,R1
        step("add_t0", 1'b1, 9'b010_000_001);
        step("add_t1", 1'b0, 9'd0);
        step("add_t2", 1'b0, 9'd0);
        step("add_t3", 1'b0, 9'd0);
        step("sub_t0", 1'b1, 9'b011_000_001);
        step("sub_t1", 1'b0, 9'd0);
        step("sub_t2", 1'b0, 9'd0);
        step("sub_t3", 1'b0, 9'd0);

        // sub R4,R5 with reset pulsed during T2
        step("sr_t0", 1'b1, 9'b011_100_101);
        step("sr_t1", 1'b0, 9'd0);
        Run = 1'b0; #2;
        chk("sr_t2", outs, expected(1'b0));
        Resetn = 1'b0; #1;
        chk("sr_async", outs, 0);
        chk("sr_ir", dut.ir_q, 0);
        pend.delete();
        @(posedge Clock); #1;
        chk("sr_nodone", Done, 0);
        Resetn = 1'b1;
        step("sr_idle", 1'b0, 9'd0);
        step("sr_refetch", 1'b1, 9'b000_110_010);
        step("sr_mv", 1'b0, 9'd0);

        // Run held high: NOP then mv R7,R0 back to back
        step("nop_t0", 1'b1, 9'b111_000_000);
        step("nop_t1", 1'b1, 9'b111_000_000);
        step("b2b_t0", 1'b1, 9'b000_111_000);
        step("b2b_t1", 1'b1, 9'b000_111_000);
        step("b2b_next", 1'b0, 9'd0);

        // randomized traffic
        for (int i = 0; i < 400; i++)
            step("rand", 1'($urandom_range(0, 1)), 9'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
